// File: rtl/eeprom_access_arbiter.sv
// eeprom_access_arbiter: shares one iic_com EEPROM engine between two requesters.
// Round-robin grant, Start_Sig/Done_Sig sequencing with a fixed idle gap after
// every transaction, and a per-transaction timeout that reports an error.
module eeprom_access_arbiter #(
    parameter int unsigned TIMEOUT    = 1000000,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0,
    input  logic       req1,
    input  logic       wr0,
    input  logic       wr1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic       err0,
    output logic       err1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       busy,
    output logic [1:0] Start_Sig,
    output logic [7:0] Addr_Sig,
    output logic [7:0] WrData,
    input  logic [7:0] RdData,
    input  logic       Done_Sig
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_grant;
    logic             owner;
    logic             owner_wr;
    logic             grant_valid;
    logic             grant_sel;
    logic             sel_wr;

    // Round-robin pick: on a tie the requester that was not granted last wins
    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = req1;
        end
        sel_wr = grant_sel ? wr1 : wr0;
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            gap_cnt    <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            owner_wr   <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= 8'h00;
            rdata1     <= 8'h00;
            busy       <= 1'b0;
            Start_Sig  <= 2'b00;
            Addr_Sig   <= 8'h00;
            WrData     <= 8'h00;
        end else begin
            // ack/err are single-cycle pulses
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        owner_wr   <= sel_wr;
                        Addr_Sig   <= grant_sel ? addr1 : addr0;
                        WrData     <= grant_sel ? wdata1 : wdata0;
                        Start_Sig  <= sel_wr ? 2'b01 : 2'b10;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // Done takes priority over a simultaneous timeout
                    if (Done_Sig || (cnt == CNT_LAST)) begin
                        Start_Sig <= 2'b00;
                        gap_cnt   <= '0;
                        state     <= GAP;
                        if (owner) begin
                            ack1 <= 1'b1;
                            err1 <= ~Done_Sig;
                            if (Done_Sig && !owner_wr) begin
                                rdata1 <= RdData;
                            end
                        end else begin
                            ack0 <= 1'b1;
                            err0 <= ~Done_Sig;
                            if (Done_Sig && !owner_wr) begin
                                rdata0 <= RdData;
                            end
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/eeprom_access_arbiter.md
Name: eeprom_access_arbiter

Overview:
- Shares the single iic_com EEPROM I2C engine between two independent requesters (e.g. a config loader and a runtime logger).
- Accepts byte-write and byte-read requests and arbitrates between them round-robin.
- Sequences the Start_Sig/Done_Sig handshake of iic_com, including the mandatory idle gap between transactions.
- Bounds every transaction with a timeout and returns read data and an error flag per requester.

Parameters:
- TIMEOUT, 1000000, CLK cycles allowed in BUSY before a transaction is aborted; must be ≥ 2.
- CNT_W, 20, width of the timeout counter; 2^CNT_W must exceed TIMEOUT.
- GAP_CYCLES, 4, CLK cycles Start_Sig is held at 2'b00 after each transaction; must be ≥ 2.

Ports:
- CLK  in  1  system clock, the same clock that drives iic_com.
- RST  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request level; held high until the matching ack.
- wr0 / wr1  in  1  1 = write, 0 = read; sampled at grant.
- addr0 / addr1  in  8  EEPROM byte address; sampled at grant.
- wdata0 / wdata1  in  8  write byte; sampled at grant.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  valid with ack; 1 = timed out.
- rdata0 / rdata1  out  8  read byte; valid from ack onward until the next read completes for that requester.
- busy  out  1  high whenever state ≠ IDLE.
- Start_Sig  out  2  to iic_com: 2'b01 = write, 2'b10 = read, 2'b00 = idle.
- Addr_Sig  out  8  to iic_com.
- WrData  out  8  to iic_com.
- RdData  in  8  from iic_com.
- Done_Sig  in  1  from iic_com; one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, RST high):
  - State = IDLE; every output = 0, including Start_Sig = 2'b00, ack*, err*, rdata* and busy.
  - Timeout counter = 0; last_grant = 1, so requester 0 wins the first tie.
  - Reset mid-transaction abandons it silently; no ack is issued.
- All outputs are registered.
- State machine: IDLE → BUSY → GAP → IDLE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester ≠ last_grant.
  - On grant (cycle t):
    - latch addr, wdata and wr of the granted requester into Addr_Sig and WrData;
    - set Start_Sig = wr ? 01 : 10, visible at t+1;
    - update last_grant, clear the counter, enter BUSY.
- BUSY:
  - Start_Sig, Addr_Sig and WrData are held constant.
  - The counter increments every cycle.
  - Done_Sig = 1:
    - Start_Sig ← 00;
    - for a read, the granted rdata ← RdData (sampled this cycle); a write leaves rdata unchanged;
    - the granted ack pulses with err = 0 on the next cycle;
    - enter GAP.
  - Counter reaches TIMEOUT−1 with no Done_Sig:
    - Start_Sig ← 00;
    - the granted ack pulses with err = 1; rdata is unchanged;
    - enter GAP.
  - Done_Sig and timeout in the same cycle: Done wins and err = 0.
- GAP:
  - Start_Sig = 00 for exactly GAP_CYCLES cycles, then IDLE.
  - No grant is made during GAP.
  - The ack pulse coincides with the first GAP cycle.
  - A requester drops req the cycle after ack. A req still high on return to IDLE is treated as a new request, subject to round-robin.
- Done_Sig outside BUSY is ignored (no state change, no ack).
- A req that drops before grant is simply not served.
- A req that drops during BUSY does not abort the transaction; its ack is still issued.
- err is meaningful only while ack is high and reads 0 otherwise.
- Minimum transaction time from grant to next possible grant = 1 + (BUSY cycles) + GAP_CYCLES.

Test Plan:
- req0 write, addr=0x00, wdata=0x12; bench model raises Done_Sig 50 cycles after Start_Sig=01 → Start_Sig=01 with Addr_Sig=0x00 and WrData=0x12 until Done; ack0 one cycle later with err0=0; Start_Sig=00 for 4 cycles; busy falls.
- req1 read, addr=0x00; model drives RdData=0x12 with Done → Start_Sig=10; ack1=1, err1=0, rdata1=0x12; rdata0 unchanged.
- req0 and req1 raised in the same cycle after reset, each held and re-raised → grant order 0,1,0,1; never two consecutive grants to one requester while the other waits.
- TIMEOUT=100, Done_Sig never asserted → Start_Sig drops to 00 exactly 100 cycles after grant; ack pulses with err=1; rdata unchanged; then normal recovery on the next request.
- RST pulsed while in BUSY → all outputs 0 immediately (asynchronously); no ack; next simultaneous request grants requester 0 first.
- Done_Sig pulsed in IDLE and in GAP → no ack and no state change; Done_Sig coincident with the timeout cycle → ack with err=0.
